// File: rtl/digit_serial_adder_ctrl.sv
// Digit-serial WIDTH-bit adder: one shared 2-bit full adder, one digit per clock, LSB first.
// Optional macro SUB_MODE_EN adds a 'sub' input for a - b (two's complement) operation.

module full_adder_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
endmodule

module digit_serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUB_MODE_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int N  = WIDTH / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
         $error("digit_serial_adder_ctrl: WIDTH must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             load, step, last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
   logic             carry;
   logic [1:0]       fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] b_cap;
   logic             cin_cap;

`ifdef SUB_MODE_EN
   // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
   assign b_cap   = sub ? ~b : b;
   assign cin_cap = sub ? 1'b1 : cin;
`else
   assign b_cap   = b;
   assign cin_cap = cin;
`endif

   full_adder_2bit u_fa (
      .a    (a_sh[1:0]),
      .b    (b_sh[1:0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last    = (cnt == CW'(N - 1));
   assign res_nxt = (res_sh >> 2) | (WIDTH'(fa_sum) << (WIDTH - 2));
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: if (start) begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            // start is honoured here so operations can run back-to-back
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (load) begin
         a_sh  <= a;
         b_sh  <= b_cap;
         carry <= cin_cap;
         cnt   <= '0;
      end else if (step) begin
         a_sh   <= a_sh >> 2;
         b_sh   <= b_sh >> 2;
         res_sh <= res_nxt;
         carry  <= fa_cout;
         cnt    <= cnt + CW'(1);
         if (last) begin
            sum  <= res_nxt;
            cout <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// Scoreboard bench for digit_serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances.
// Stimulus pushes expected {cout,sum}; a negedge monitor pops on done.

module tb_digit_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       start, cin, busy, done, cout;
   logic [7:0] a, b, sum;
   logic       start2, cin2, busy2, done2, cout2;
   logic [1:0] a2, b2, sum2;
`ifdef SUB_MODE_EN
   logic       sub;
`endif

   digit_serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SUB_MODE_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   digit_serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SUB_MODE_EN
      .sub(sub),
`endif
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [8:0] q  [$];
   logic [2:0] q2 [$];
   int         bcnt, bcnt2;
   logic [8:0] prev;
   logic [2:0] prev2;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got event, expected none at %0t", nm, $time);
   endtask

   // Monitor: pops expectations on done, checks busy length and output stability.
   always @(negedge clk) begin
      logic [8:0] e;
      logic [2:0] e2;
      if (!rst_n) begin
         bcnt  = 0;
         bcnt2 = 0;
         prev  = {cout, sum};
         prev2 = {cout2, sum2};
      end else begin
         if (done) begin
            if (q.size() == 0) flag("unexpected_done8");
            else begin
               e = q.pop_front();
               check("result8", {23'd0, cout, sum}, {23'd0, e});
               check("busy_cycles8", bcnt, 4);
            end
            bcnt = 0;
         end else begin
            check("hold8", {23'd0, cout, sum}, {23'd0, prev});
         end
         prev = {cout, sum};
         if (busy) bcnt++;

         if (done2) begin
            if (q2.size() == 0) flag("unexpected_done2");
            else begin
               e2 = q2.pop_front();
               check("result2", {29'd0, cout2, sum2}, {29'd0, e2});
               check("busy_cycles2", bcnt2, 1);
            end
            bcnt2 = 0;
         end else begin
            check("hold2", {29'd0, cout2, sum2}, {29'd0, prev2});
         end
         prev2 = {cout2, sum2};
         if (busy2) bcnt2++;
      end
   end

   task automatic drain();
      for (int i = 0; i < 40 && (q.size() != 0 || q2.size() != 0 || busy || done); i++)
         @(posedge clk);
      if (q.size() != 0 || q2.size() != 0) begin
         flag("timeout_drain");
         q.delete();
         q2.delete();
      end
      #1;
   endtask

   task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic tsub, input logic [8:0] exp);
`ifdef SUB_MODE_EN
      sub = tsub;
`endif
      q.push_back(exp);
      a = ta; b = tb; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // operands wander after capture; must not matter
      a = ~ta; b = ~tb; cin = ~tc;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 0; a = 0; b = 0; cin = 0;
      start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
`ifdef SUB_MODE_EN
      sub = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_sum",  {24'd0, sum},  0);
      check("rst_cout", {31'd0, cout}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(8'hA5, 8'h3C, 1'b0, 1'b0, 9'h0E1);
      issue(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
      issue(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);

      // start held high across two operations; operand change during RUN is ignored
      for (int k = 0; k < 2; k++) begin
         q.push_back(9'h003);
         a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
         @(posedge clk); #1;
         a = 8'h10; b = 8'h20;
         repeat (3) @(posedge clk);
         #1;
         a = 8'h01; b = 8'h02;
         @(posedge clk); #1;
      end
      start = 1'b0;
      drain();

      // reset mid-RUN after two digits
      a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_done", {31'd0, done}, 0);
      check("midrst_sum",  {24'd0, sum},  0);
      check("midrst_cout", {31'd0, cout}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      issue(8'h80, 8'h80, 1'b1, 1'b0, 9'h101);

      // WIDTH=2 instance
      q2.push_back(3'b101);
      a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      drain();

`ifdef SUB_MODE_EN
      issue(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
      issue(8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF);
      issue(8'h10, 8'h01, 1'b0, 1'b0, 9'h011);
`endif

      repeat (5) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
